pipelined_csel_adder: RTL and testbench



---
 rtl/pipelined_csel_adder_pkg.sv | 35 +++
 rtl/pipelined_csel_adder_csel_block.sv | 21 ++
 rtl/pipelined_csel_adder.sv | 147 ++++++++++++++
 tb/tb_pipelined_csel_adder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_csel_adder_pkg.sv
// Shared constants and helpers for the pipelined carry-select adder.
// Defaults, stage-count derivation and parameter legality check.
package pipelined_csel_adder_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;
  localparam int DEF_BLOCK = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int stages_of(
    input int w,
    input int c
  );
    return w / c;
  endfunction

  // 0+1+...+k; sizes the triangular per-stage sum and operand buses
  function automatic int tri_of(input int k);
    return (k * (k + 1)) / 2;
  endfunction

  function automatic bit legal(
    input int w,
    input int c,
    input int b
  );
    return (w > 0) && (c > 0) && (b > 0) &&
           (w % c == 0) && (c % b == 0);
  endfunction

endpackage

// File: rtl/pipelined_csel_adder_csel_block.sv
// BLOCK-bit carry-select slice: both carry-in cases precomputed.
// Ports: x, y operands; cin selects the result; s sum, cout carry.
module csel_block #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] r0;
  logic [W:0] r1;

  assign r0 = {1'b0, x} + {1'b0, y};
  assign r1 = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, 1'b1};

  assign {cout, s} = cin ? r1 : r0;

endmodule

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select add/sub, CHUNK bits resolved per stage.
// Ports: valid/ready in (a,b,cin,sub), valid/ready out (sum,cout,ovf).
module pipelined_csel_adder
  import pipelined_csel_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK,
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = stages_of(WIDTH, CHUNK);
  localparam int NB     = CHUNK / BLOCK;
  localparam int S_TOT  = CHUNK * tri_of(STAGES);
  localparam int R_TOT  = (STAGES > 1) ?
                          CHUNK * tri_of(STAGES - 1) : 1;

  if (!legal(WIDTH, CHUNK, BLOCK)) begin : g_bad
    $error("WIDTH/CHUNK/BLOCK must divide evenly");
  end

  // Stage k owns s[(k+1)*CHUNK] resolved bits and the
  // (STAGES-1-k)*CHUNK unconsumed operand bits, packed back to back.
  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] c_q, c_d;
  logic [S_TOT-1:0]  s_q, s_d;
  logic [R_TOT-1:0]  ra_q, ra_d;
  logic [R_TOT-1:0]  rb_q, rb_d;
  logic              ovf_q, ovf_d;

  logic             stall;
  logic [WIDTH-1:0] beff;
  logic             c0;

  assign stall = v_q[STAGES-1] & ~out_ready;
  assign beff  = (op_e'(sub) == OP_SUB) ? ~b : b;
  assign c0    = (op_e'(sub) == OP_SUB) | cin;

  if (STAGES == 1) begin : g_norem
    assign ra_d = '0;
    assign rb_d = '0;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int SO = CHUNK * tri_of(k);
    localparam int RO = CHUNK * (tri_of(STAGES - 1) -
                                 tri_of(STAGES - 1 - k));
    localparam int RW = CHUNK * (STAGES - 1 - k);

    logic [CHUNK-1:0] xa;
    logic [CHUNK-1:0] xb;
    logic [CHUNK-1:0] sc;
    logic             ci;

    if (k == 0) begin : g_src
      assign xa     = a[CHUNK-1:0];
      assign xb     = beff[CHUNK-1:0];
      assign ci     = c0;
      assign v_d[0] = in_valid;
      assign s_d[SO +: CHUNK] = sc;
      if (RW > 0) begin : g_rem
        assign ra_d[RO +: RW] = a[WIDTH-1:CHUNK];
        assign rb_d[RO +: RW] = beff[WIDTH-1:CHUNK];
      end
    end else begin : g_src
      localparam int PSO = CHUNK * tri_of(k - 1);
      localparam int PRO = CHUNK * (tri_of(STAGES - 1) -
                                    tri_of(STAGES - k));
      assign xa     = ra_q[PRO +: CHUNK];
      assign xb     = rb_q[PRO +: CHUNK];
      assign ci     = c_q[k-1];
      assign v_d[k] = v_q[k-1];
      assign s_d[SO +: (k + 1) * CHUNK] =
        {sc, s_q[PSO +: k * CHUNK]};
      if (RW > 0) begin : g_rem
        assign ra_d[RO +: RW] = ra_q[PRO + CHUNK +: RW];
        assign rb_d[RO +: RW] = rb_q[PRO + CHUNK +: RW];
      end
    end

    // Select chain: each block's carry picks the next block's result
    for (genvar j = 0; j < NB; j++) begin : g_blk
      logic bci;
      logic bco;
      if (j == 0) begin : g_ci
        assign bci = ci;
      end else begin : g_ci
        assign bci = g_blk[j-1].bco;
      end
      csel_block #(
        .W (BLOCK)
      ) u_blk (
        .x    (xa[j*BLOCK +: BLOCK]),
        .y    (xb[j*BLOCK +: BLOCK]),
        .cin  (bci),
        .s    (sc[j*BLOCK +: BLOCK]),
        .cout (bco)
      );
    end

    assign c_d[k] = g_blk[NB-1].bco;

    // Top chunk carries both sign bits (a and effective b)
    if (k == STAGES - 1) begin : g_ovf
      assign ovf_d = (xa[CHUNK-1] == xb[CHUNK-1]) &&
                     (sc[CHUNK-1] != xa[CHUNK-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      s_q   <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      ovf_q <= 1'b0;
    end else if (!stall) begin
      v_q   <= v_d;
      c_q   <= c_d;
      s_q   <= s_d;
      ra_q  <= ra_d;
      rb_q  <= rb_d;
      ovf_q <= ovf_d;
    end
  end

  assign in_ready  = ~stall;
  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[S_TOT-1 -: WIDTH];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Directed-vector bench for pipelined_csel_adder (32/8/4).
// Vector table, streams with scoreboard, stall and reset cases.
module tb_pipelined_csel_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        sb;
    logic [31:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  vec_t        vt [12];
  logic [31:0] ba [16];
  logic [31:0] bb [16];
  logic        bc [16];
  logic        bs [16];

  pipelined_csel_adder #(
    .WIDTH (32),
    .CHUNK (8),
    .BLOCK (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       name,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h",
               name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic        c,
    input logic        s
  );
    logic [31:0] be;
    logic [32:0] r;
    exp_t        e;
    be   = s ? ~y : y;
    r    = {1'b0, x} + {1'b0, be} + {32'd0, s | c};
    e.s  = r[31:0];
    e.co = r[32];
    e.ov = (x[31] == be[31]) && (r[31] != x[31]);
    return e;
  endfunction

  // Stream n beats from ba/bb/bc/bs; out_ready low for cycles lo..hi
  task automatic run_stream(
    input int    n,
    input int    lo,
    input int    hi,
    input string tag
  );
    exp_t q[$];
    int   sent;
    int   got;
    int   cyc;
    bit   win;
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < n && cyc < 200) begin
      win       = (cyc >= lo) && (cyc <= hi);
      out_ready = !win;
      in_valid  = (sent < n);
      if (sent < n) begin
        a   = ba[sent];
        b   = bb[sent];
        cin = bc[sent];
        sub = bs[sent];
      end
      #1;
      chk({tag, "_in_ready"}, {31'd0, in_ready}, {31'd0, !win});
      if (out_valid) begin
        if (q.size() == 0) begin
          chk({tag, "_spurious"}, {31'd0, out_valid}, 32'd0);
        end else begin
          chk({tag, "_sum"}, sum, q[0].s);
          chk({tag, "_cout"}, {31'd0, cout}, {31'd0, q[0].co});
          chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, q[0].ov});
          if (out_ready) begin
            void'(q.pop_front());
            got++;
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, cin, sub));
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk({tag, "_count"}, got, n);
  endtask

  initial begin
    vt[0]  = {32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0,
              32'h00000000, 1'b1, 1'b0};
    vt[1]  = {32'h00000005, 32'h00000007, 1'b0, 1'b1,
              32'hFFFFFFFE, 1'b0, 1'b0};
    vt[2]  = {32'h80000000, 32'h00000001, 1'b0, 1'b1,
              32'h7FFFFFFF, 1'b1, 1'b1};
    vt[3]  = {32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0,
              32'h80000000, 1'b0, 1'b1};
    vt[4]  = {32'hEC1CFF46, 32'h12345678, 1'b1, 1'b0,
              32'hFE5155BF, 1'b0, 1'b0};
    vt[5]  = {32'h0000FFFF, 32'h00000001, 1'b1, 1'b0,
              32'h00010001, 1'b0, 1'b0};
    vt[6]  = {32'h12345678, 32'h12345678, 1'b0, 1'b1,
              32'h00000000, 1'b1, 1'b0};
    vt[7]  = {32'h80000000, 32'h80000000, 1'b0, 1'b0,
              32'h00000000, 1'b1, 1'b1};
    vt[8]  = {32'h00000000, 32'h00000000, 1'b1, 1'b1,
              32'h00000000, 1'b1, 1'b0};
    vt[9]  = {32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0,
              32'h00000000, 1'b1, 1'b0};
    vt[10] = {32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0, 1'b0,
              32'hFFFFFFFF, 1'b0, 1'b0};
    vt[11] = {32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1,
              32'h80000000, 1'b0, 1'b1};

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", sum, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick();

    // Directed vectors, one at a time, with latency
    for (int i = 0; i < 12; i++) begin
      a        = vt[i].a;
      b        = vt[i].b;
      cin      = vt[i].ci;
      sub      = vt[i].sb;
      in_valid = 1'b1;
      for (int t = 1; t <= 4; t++) begin
        tick();
        in_valid = 1'b0;
        chk($sformatf("vec%0d_lat%0d", i, t),
            {31'd0, out_valid}, {31'd0, t == 4});
      end
      chk($sformatf("vec%0d_sum", i), sum, vt[i].s);
      chk($sformatf("vec%0d_cout", i),
          {31'd0, cout}, {31'd0, vt[i].co});
      chk($sformatf("vec%0d_ovf", i),
          {31'd0, ovf}, {31'd0, vt[i].ov});
      tick();
    end

    // Backpressure: 8 beats, out_ready low cycles 5-7
    for (int i = 0; i < 8; i++) begin
      ba[i] = 32'(i);
      bb[i] = 32'h100 * 32'(i);
      bc[i] = 1'b0;
      bs[i] = 1'b0;
    end
    run_stream(8, 5, 7, "bp");
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("bp_no_dup", {31'd0, out_valid}, 32'd0);
    end

    // Back-to-back random beats against the model
    for (int i = 0; i < 12; i++) begin
      ba[i] = $urandom;
      bb[i] = $urandom;
      bc[i] = 1'($urandom_range(1));
      bs[i] = 1'($urandom_range(1));
    end
    run_stream(12, -1, -1, "rnd");

    // Held result, then asynchronous reset drops it
    a         = 32'd3;
    b         = 32'd4;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("hold_valid", {31'd0, out_valid}, 32'd1);
    chk("hold_sum", sum, 32'd7);
    chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_sum", sum, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #3;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();

    // Mid-flight reset: three beats in flight are discarded
    for (int i = 0; i < 3; i++) begin
      a        = 32'd10 + 32'(20 * i);
      b        = 32'd20 + 32'(20 * i);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("mid_no_stale", {31'd0, out_valid}, 32'd0);
    end
    a        = 32'd1;
    b        = 32'd2;
    cin      = 1'b0;
    sub      = 1'b0;
    in_valid = 1'b1;
    for (int t = 1; t <= 4; t++) begin
      tick();
      in_valid = 1'b0;
      chk($sformatf("post_rst_lat%0d", t),
          {31'd0, out_valid}, {31'd0, t == 4});
    end
    chk("post_rst_sum", sum, 32'd3);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
